// File: rtl/wb_pkg.sv
// Shared Wishbone widths, slave FSM state encoding and address-check helper
// for the RAM responder and its bus interface.
package wb_pkg;

    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;
    localparam int WB_ADR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_slv_state_e;

    // Misaligned byte address or word index beyond the RAM is answered with err.
    function automatic logic wb_adr_bad(input logic [WB_ADR_W-1:0] adr,
                                        input int unsigned depth);
        return (adr[1:0] != 2'b00) || ({2'b00, adr[WB_ADR_W-1:2]} >= depth[31:0]);
    endfunction

endpackage

// File: rtl/wb_bus_t.sv
// Wishbone classic bus bundle between one xbar master-side port and a target.
interface wb_bus_t #(
    parameter int TAGSIZE = 2
) ();
    import wb_pkg::*;

    logic [WB_ADR_W-1:0] wb_adr;
    logic [WB_DAT_W-1:0] wb_dat_ms;
    logic [WB_DAT_W-1:0] wb_dat_sm;
    logic [WB_SEL_W-1:0] wb_sel;
    logic                wb_we;
    logic                wb_cyc;
    logic                wb_stb;
    logic                wb_lock;
    logic [TAGSIZE-1:0]  wb_tga;
    logic [TAGSIZE-1:0]  wb_tgd_ms;
    logic [TAGSIZE-1:0]  wb_tgc;
    logic [TAGSIZE-1:0]  wb_tgd_sm;
    logic                wb_ack;
    logic                wb_err;
    logic                wb_rty;
    logic                wb_gnt;

    modport slave (
        input  wb_adr, wb_dat_ms, wb_sel, wb_we, wb_cyc, wb_stb, wb_lock,
               wb_tga, wb_tgd_ms, wb_tgc,
        output wb_dat_sm, wb_tgd_sm, wb_ack, wb_err, wb_rty, wb_gnt
    );

    modport master (
        output wb_adr, wb_dat_ms, wb_sel, wb_we, wb_cyc, wb_stb, wb_lock,
               wb_tga, wb_tgd_ms, wb_tgc,
        input  wb_dat_sm, wb_tgd_sm, wb_ack, wb_err, wb_rty, wb_gnt
    );

endinterface

// File: rtl/wb_sp_ram.sv
// Single-port word RAM with per-byte write enables and registered read data.
// Contents are deliberately not reset.
module wb_sp_ram
    import wb_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                clk_i,
    input  logic                en_i,
    input  logic [WB_SEL_W-1:0] we_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [WB_DAT_W-1:0] wdata_i,
    output logic [WB_DAT_W-1:0] rdata_o
);

    logic [WB_DAT_W-1:0] mem_q [DEPTH_WORDS];

    // Byte-lane writes; a read (no lane enabled) refreshes the output register.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < WB_SEL_W; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            if (we_i == '0) begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic RAM target: accepts one request, waits WAIT_STATES cycles,
// then commits and answers with a single-cycle ack or err.
module wb_ram_slave
    import wb_pkg::*;
#(
    parameter int TAGSIZE     = 2,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    wb_bus_t.slave   wb_bus
);

    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    wb_slv_state_e       state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic                we_q, we_d;
    logic [WB_SEL_W-1:0] sel_q, sel_d;
    logic [WB_DAT_W-1:0] dat_q, dat_d;
    logic [TAGSIZE-1:0]  tga_q, tga_d;
    logic                bad_q, bad_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                rdv_q, rdv_d;

    logic                req_s, bus_bad_s, commit_s;
    logic [AW-1:0]       cur_idx_s;
    logic                cur_we_s, cur_bad_s;
    logic [WB_SEL_W-1:0] cur_sel_s;
    logic [WB_DAT_W-1:0] cur_dat_s;
    logic                ram_en_s;
    logic [WB_SEL_W-1:0] ram_we_s;
    logic [WB_DAT_W-1:0] ram_rdata_s;
    logic                unused_s;

    assign req_s     = wb_bus.wb_cyc & wb_bus.wb_stb;
    assign bus_bad_s = wb_adr_bad(wb_bus.wb_adr, DEPTH_WORDS);
    assign unused_s  = ^{wb_bus.wb_tgd_ms, wb_bus.wb_tgc, wb_bus.wb_lock};

    // With zero wait states the commit happens on the accept edge, so take the bus fields directly.
    always_comb begin
        if (state_q == IDLE) begin
            cur_idx_s = wb_bus.wb_adr[AW+1:2];
            cur_we_s  = wb_bus.wb_we;
            cur_sel_s = wb_bus.wb_sel;
            cur_dat_s = wb_bus.wb_dat_ms;
            cur_bad_s = bus_bad_s;
        end else begin
            cur_idx_s = idx_q;
            cur_we_s  = we_q;
            cur_sel_s = sel_q;
            cur_dat_s = dat_q;
            cur_bad_s = bad_q;
        end
    end

    // Request FSM: accept, count wait states, abort on cyc loss, commit on entry to RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        we_d     = we_q;
        sel_d    = sel_q;
        dat_d    = dat_q;
        tga_d    = tga_q;
        bad_d    = bad_q;
        commit_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    idx_d = wb_bus.wb_adr[AW+1:2];
                    we_d  = wb_bus.wb_we;
                    sel_d = wb_bus.wb_sel;
                    dat_d = wb_bus.wb_dat_ms;
                    tga_d = wb_bus.wb_tga;
                    bad_d = bus_bad_s;
                    cnt_d = WS_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_d  = RESP;
                        commit_s = 1'b1;
                    end else begin
                        state_d  = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!wb_bus.wb_cyc) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d  = RESP;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_d    = commit_s & ~cur_bad_s;
        err_d    = commit_s & cur_bad_s;
        rdv_d    = commit_s & ~cur_bad_s & ~cur_we_s;
        ram_en_s = commit_s & ~cur_bad_s;
        ram_we_s = cur_we_s ? cur_sel_s : {WB_SEL_W{1'b0}};
    end

    // State and response registers; async reset clears the response immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            tga_q   <= '0;
            bad_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            tga_q   <= tga_d;
            bad_q   <= bad_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdv_q   <= rdv_d;
        end
    end

    wb_sp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .en_i    (ram_en_s),
        .we_i    (ram_we_s),
        .addr_i  (cur_idx_s),
        .wdata_i (cur_dat_s),
        .rdata_o (ram_rdata_s)
    );

    assign wb_bus.wb_ack    = ack_q;
    assign wb_bus.wb_err    = err_q;
    assign wb_bus.wb_dat_sm = rdv_q ? ram_rdata_s : 32'h0000_0000;
    assign wb_bus.wb_tgd_sm = tga_q;
    assign wb_bus.wb_rty    = 1'b0;
    assign wb_bus.wb_gnt    = 1'b0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: vector table on a WAIT_STATES=1 instance,
// hand sequences for abort (WAIT_STATES=3), back-to-back strobes and reset.
module tb_wb_ram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] drv_adr = 32'h0;
    logic [31:0] drv_dat = 32'h0;
    logic [3:0]  drv_sel = 4'h0;
    logic        drv_we  = 1'b0;
    logic        drv_stb = 1'b0;
    logic [1:0]  drv_tga = 2'd0;
    logic        cyc1 = 1'b0;
    logic        cyc3 = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_bus_t #(.TAGSIZE(2)) bus1 ();
    wb_bus_t #(.TAGSIZE(2)) bus3 ();

    assign bus1.wb_adr = drv_adr;    assign bus3.wb_adr = drv_adr;
    assign bus1.wb_dat_ms = drv_dat; assign bus3.wb_dat_ms = drv_dat;
    assign bus1.wb_sel = drv_sel;    assign bus3.wb_sel = drv_sel;
    assign bus1.wb_we = drv_we;      assign bus3.wb_we = drv_we;
    assign bus1.wb_stb = drv_stb;    assign bus3.wb_stb = drv_stb;
    assign bus1.wb_tga = drv_tga;    assign bus3.wb_tga = drv_tga;
    assign bus1.wb_cyc = cyc1;       assign bus3.wb_cyc = cyc3;
    assign bus1.wb_lock = 1'b0;      assign bus3.wb_lock = 1'b0;
    assign bus1.wb_tgd_ms = 2'd0;    assign bus3.wb_tgd_ms = 2'd0;
    assign bus1.wb_tgc = 2'd0;       assign bus3.wb_tgc = 2'd0;

    wb_ram_slave #(.TAGSIZE(2), .DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (
        .clk_i (clk), .rst_i (rst), .wb_bus (bus1.slave)
    );
    wb_ram_slave #(.TAGSIZE(2), .DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
        .clk_i (clk), .rst_i (rst), .wb_bus (bus3.slave)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [1:0]  tga;
        logic        ack;
        logic        err;
        logic [31:0] rdat;
        logic [1:0]  tgd;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input int which, input logic we_i, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] t,
                        output logic ack_o, output logic err_o, output logic [31:0] rd_o,
                        output logic [1:0] tg_o, output int lat_o, output logic one_o);
        logic a_s, e_s;
        @(negedge clk);
        drv_we = we_i; drv_adr = a; drv_dat = d; drv_sel = s; drv_tga = t; drv_stb = 1'b1;
        if (which == 3) cyc3 = 1'b1; else cyc1 = 1'b1;
        ack_o = 1'b0; err_o = 1'b0; rd_o = 32'h0; tg_o = 2'd0; lat_o = 99;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            a_s = (which == 3) ? bus3.wb_ack : bus1.wb_ack;
            e_s = (which == 3) ? bus3.wb_err : bus1.wb_err;
            if (a_s || e_s) begin
                ack_o = a_s; err_o = e_s; lat_o = i;
                rd_o  = (which == 3) ? bus3.wb_dat_sm : bus1.wb_dat_sm;
                tg_o  = (which == 3) ? bus3.wb_tgd_sm : bus1.wb_tgd_sm;
                break;
            end
        end
        cyc1 = 1'b0; cyc3 = 1'b0; drv_stb = 1'b0;
        @(negedge clk);
        one_o = (which == 3) ? !(bus3.wb_ack || bus3.wb_err) : !(bus1.wb_ack || bus1.wb_err);
    endtask

    initial begin
        logic ack, err, one, seen;
        logic [31:0] rd;
        logic [1:0] tg;
        int lat, nack, first_at, second_at;
        logic [31:0] d0, d1;

        vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'd2, 1'b1, 1'b0, 32'h0, 2'd2};
        vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 2'd1, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'd1};
        vt[2]  = '{1'b1, 32'h0000_0010, 32'h00AA_0000, 4'h4, 2'd3, 1'b1, 1'b0, 32'h0, 2'd3};
        vt[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 2'd0, 1'b1, 1'b0, 32'hDEAA_BEEF, 2'd0};
        vt[4]  = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 2'd2, 1'b0, 1'b1, 32'h0, 2'd2};
        vt[5]  = '{1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 4'hF, 2'd1, 1'b0, 1'b1, 32'h0, 2'd1};
        vt[6]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 2'd3, 1'b1, 1'b0, 32'hDEAA_BEEF, 2'd3};
        vt[7]  = '{1'b1, 32'h0000_0FFC, 32'hA5A5_5A5A, 4'hF, 2'd0, 1'b1, 1'b0, 32'h0, 2'd0};
        vt[8]  = '{1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 2'd1, 1'b1, 1'b0, 32'hA5A5_5A5A, 2'd1};
        vt[9]  = '{1'b1, 32'h0000_0014, 32'h0102_0304, 4'hF, 2'd2, 1'b1, 1'b0, 32'h0, 2'd2};
        vt[10] = '{1'b1, 32'h0000_0014, 32'h1111_1111, 4'h0, 2'd3, 1'b1, 1'b0, 32'h0, 2'd3};
        vt[11] = '{1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'h9, 2'd0, 1'b1, 1'b0, 32'h0, 2'd0};
        vt[12] = '{1'b0, 32'h0000_0014, 32'h0,         4'hF, 2'd1, 1'b1, 1'b0, 32'hAA02_03DD, 2'd1};
        vt[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 2'd2, 1'b0, 1'b1, 32'h0, 2'd2};
        vt[14] = '{1'b0, 32'h0000_0011, 32'h0,         4'hF, 2'd3, 1'b0, 1'b1, 32'h0, 2'd3};

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst.ack", {31'd0, bus1.wb_ack}, 32'd0);
        chk("rst.err", {31'd0, bus1.wb_err}, 32'd0);
        chk("rst.dat", bus1.wb_dat_sm, 32'h0);
        chk("rst.tgd", {30'd0, bus1.wb_tgd_sm}, 32'd0);
        chk("rst.rty_gnt", {30'd0, bus1.wb_rty, bus1.wb_gnt}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 15; v++) begin
            xfer(1, vt[v].we, vt[v].adr, vt[v].dat, vt[v].sel, vt[v].tga, ack, err, rd, tg, lat, one);
            chk($sformatf("v%0d.ack", v), {31'd0, ack}, {31'd0, vt[v].ack});
            chk($sformatf("v%0d.err", v), {31'd0, err}, {31'd0, vt[v].err});
            chk($sformatf("v%0d.dat", v), rd, vt[v].rdat);
            chk($sformatf("v%0d.tgd", v), {30'd0, tg}, {30'd0, vt[v].tgd});
            chk($sformatf("v%0d.lat", v), lat, 32'd2);
            chk($sformatf("v%0d.width", v), {31'd0, one}, 32'd1);
        end

        // WAIT_STATES=3: abort a write by dropping cyc one cycle after accept
        xfer(3, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 2'd1, ack, err, rd, tg, lat, one);
        chk("ws3.wr.ack", {31'd0, ack}, 32'd1);
        chk("ws3.wr.lat", lat, 32'd4);
        @(negedge clk);
        drv_we = 1'b1; drv_adr = 32'h20; drv_dat = 32'h1234_5678; drv_sel = 4'hF; drv_stb = 1'b1; cyc3 = 1'b1;
        @(negedge clk);
        cyc3 = 1'b0; drv_stb = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus3.wb_ack || bus3.wb_err) seen = 1'b1;
        end
        chk("abort.noresp", {31'd0, seen}, 32'd0);
        xfer(3, 1'b0, 32'h20, 32'h0, 4'hF, 2'd2, ack, err, rd, tg, lat, one);
        chk("abort.reread", rd, 32'hCAFE_F00D);
        chk("abort.lat", lat, 32'd4);

        // back-to-back reads with stb held high
        xfer(1, 1'b1, 32'h0, 32'h1122_3344, 4'hF, 2'd0, ack, err, rd, tg, lat, one);
        xfer(1, 1'b1, 32'h4, 32'h5566_7788, 4'hF, 2'd0, ack, err, rd, tg, lat, one);
        @(negedge clk);
        drv_we = 1'b0; drv_adr = 32'h0; drv_stb = 1'b1; cyc1 = 1'b1;
        nack = 0; first_at = -1; second_at = -1; d0 = 32'h0; d1 = 32'h0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus1.wb_ack) begin
                nack++;
                if (nack == 1) begin
                    first_at = i; d0 = bus1.wb_dat_sm; drv_adr = 32'h4;
                end else if (nack == 2) begin
                    second_at = i; d1 = bus1.wb_dat_sm; drv_stb = 1'b0; cyc1 = 1'b0;
                end
            end
        end
        cyc1 = 1'b0; drv_stb = 1'b0;
        chk("b2b.count", nack, 32'd2);
        chk("b2b.first", first_at, 32'd2);
        chk("b2b.spacing", second_at - first_at, 32'd3);
        chk("b2b.d0", d0, 32'h1122_3344);
        chk("b2b.d1", d1, 32'h5566_7788);

        // reset during WAIT of a write: word must keep its old value
        xfer(1, 1'b1, 32'h30, 32'h0BAD_F00D, 4'hF, 2'd0, ack, err, rd, tg, lat, one);
        @(negedge clk);
        drv_we = 1'b1; drv_adr = 32'h30; drv_dat = 32'hFFFF_FFFF; drv_sel = 4'hF; drv_stb = 1'b1; cyc1 = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw.ack_now", {31'd0, bus1.wb_ack | bus1.wb_err}, 32'd0);
        @(negedge clk);
        chk("rstw.ack_next", {31'd0, bus1.wb_ack | bus1.wb_err}, 32'd0);
        cyc1 = 1'b0; drv_stb = 1'b0; rst = 1'b0;
        xfer(1, 1'b0, 32'h30, 32'h0, 4'hF, 2'd1, ack, err, rd, tg, lat, one);
        chk("rstw.read_ack", {31'd0, ack}, 32'd1);
        chk("rstw.read_dat", rd, 32'h0BAD_F00D);

        // reset in the RESP cycle: outputs drop at once, committed write stays
        @(negedge clk);
        drv_we = 1'b1; drv_adr = 32'h34; drv_dat = 32'h600D_CAFE; drv_sel = 4'hF; drv_tga = 2'd3;
        drv_stb = 1'b1; cyc1 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus1.wb_ack) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rstr.ack_seen", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstr.ack_async", {31'd0, bus1.wb_ack}, 32'd0);
        chk("rstr.tgd_async", {30'd0, bus1.wb_tgd_sm}, 32'd0);
        cyc1 = 1'b0; drv_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        xfer(1, 1'b0, 32'h34, 32'h0, 4'hF, 2'd2, ack, err, rd, tg, lat, one);
        chk("rstr.read_dat", rd, 32'h600D_CAFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
